graph_load_sequencer: RTL and testbench

GRAPH_LOAD_SEQUENCER -- requirements
Module: graph_load_sequencer

---
 rtl/graph_load_sequencer.sv | 132 +++++++++++++
 tb/tb_graph_load_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/graph_load_sequencer.sv
// Buffers decoded graph edges in a small FIFO, streams them into edge RAM, then launches the solver.
// Optional sticky overflow flag: define GRAPH_LOAD_OVERFLOW_FLAG_EN.
module graph_load_sequencer #(
  parameter int NODE_WIDTH = 15,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    edge_valid,
  input  logic [NODE_WIDTH-1:0]   src_node,
  input  logic [NODE_WIDTH-1:0]   dst_node,
  input  logic                    decoding_done,
  output logic                    ram_wr_en,
  input  logic                    ram_wr_ready,
  output logic [ADDR_WIDTH-1:0]   ram_wr_addr,
  output logic [2*NODE_WIDTH-1:0] ram_wr_data,
  output logic                    solver_start,
  input  logic                    solver_done,
  output logic [ADDR_WIDTH:0]     edge_count,
  output logic                    overflow,
  output logic                    all_done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int DW = 2 * NODE_WIDTH;
  localparam logic [ADDR_WIDTH+1:0] CAP   = (ADDR_WIDTH+2)'(1) << ADDR_WIDTH;
  localparam logic [PW:0]           DEPTH = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_SOLVE, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_rst_sync;
  logic                  w_rst_n;
  logic [DW-1:0]         r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [PW:0]           r_occ;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_start;
  logic                  w_accepting, w_wr_en, w_pop, w_full, w_at_cap;
  logic                  w_push_req, w_push;
  logic [ADDR_WIDTH+1:0] w_total;

  // Assertion reaches every flop immediately; release is delayed one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 1'b0;
    else        r_rst_sync <= 1'b1;
  end
  assign w_rst_n = r_rst_sync;

  assign w_accepting = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign w_wr_en     = ((r_state == S_LOAD) || (r_state == S_DRAIN)) && (r_occ != '0);
  assign w_pop       = w_wr_en && ram_wr_ready;
  assign w_full      = (r_occ == DEPTH);
  // A pop moves one edge from buffer to RAM, so count+occupancy is unaffected by it.
  assign w_total     = {1'b0, r_count} + (ADDR_WIDTH+2)'(r_occ);
  assign w_at_cap    = (w_total >= CAP);
  assign w_push_req  = w_accepting && edge_valid;
  assign w_push      = w_push_req && !(w_full && !w_pop) && !w_at_cap;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {src_node, dst_node};
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_occ   <= '0;
      r_addr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop) begin
        r_rptr  <= r_rptr + PW'(1);
        r_addr  <= r_addr + ADDR_WIDTH'(1);
        r_count <= r_count + (ADDR_WIDTH+1)'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + (PW+1)'(1);
        2'b01:   r_occ <= r_occ - (PW+1)'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= S_IDLE;
      r_start <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_start <= (w_state_nxt == S_SOLVE) && (r_state != S_SOLVE);
    end
  end

  // End-of-input wins in IDLE too, so a lone edge arriving with it still drains.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (decoding_done) w_state_nxt = S_DRAIN;
               else if (edge_valid) w_state_nxt = S_LOAD;
      S_LOAD:  if (decoding_done) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_occ == '0) w_state_nxt = S_SOLVE;
      S_SOLVE: if (solver_done) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef GRAPH_LOAD_OVERFLOW_FLAG_EN
  logic r_ovf;
  logic w_drop;
  assign w_drop = w_push_req && !w_push;
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n)    r_ovf <= 1'b0;
    else if (w_drop) r_ovf <= 1'b1;
  end
  assign overflow = r_ovf;
`else
  assign overflow = 1'b0;
`endif

  assign ram_wr_en    = w_wr_en;
  assign ram_wr_data  = w_wr_en ? r_mem[r_rptr] : '0;
  assign ram_wr_addr  = r_addr;
  assign edge_count   = r_count;
  assign solver_start = r_start;
  assign all_done     = (r_state == S_DONE);

endmodule

// File: tb/tb_graph_load_sequencer.sv
// Bench for graph_load_sequencer: a default instance and a 4-entry-RAM instance share stimulus,
// each checked every cycle against a queue-based model of the load/drain/solve flow.
module tb_graph_load_sequencer;

  localparam int NW    = 15;
  localparam int DEPTH = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic edge_valid = 1'b0, decoding_done = 1'b0, ram_wr_ready = 1'b0, solver_done = 1'b0;
  logic [NW-1:0] src_node = '0, dst_node = '0;

  logic        en0, st0, ovf0, ad0;
  logic [11:0] addr0;
  logic [29:0] data0;
  logic [12:0] cnt0;
  logic        en1, st1, ovf1, ad1;
  logic [1:0]  addr1;
  logic [29:0] data1;
  logic [2:0]  cnt1;

  always #5 clk = ~clk;

  graph_load_sequencer #(.NODE_WIDTH(NW), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(12)) u_dut (
    .clk(clk), .rst_n(rst_n), .edge_valid(edge_valid), .src_node(src_node), .dst_node(dst_node),
    .decoding_done(decoding_done), .ram_wr_en(en0), .ram_wr_ready(ram_wr_ready),
    .ram_wr_addr(addr0), .ram_wr_data(data0), .solver_start(st0), .solver_done(solver_done),
    .edge_count(cnt0), .overflow(ovf0), .all_done(ad0));

  graph_load_sequencer #(.NODE_WIDTH(NW), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(2)) u_small (
    .clk(clk), .rst_n(rst_n), .edge_valid(edge_valid), .src_node(src_node), .dst_node(dst_node),
    .decoding_done(decoding_done), .ram_wr_en(en1), .ram_wr_ready(ram_wr_ready),
    .ram_wr_addr(addr1), .ram_wr_data(data1), .solver_start(st1), .solver_done(solver_done),
    .edge_count(cnt1), .overflow(ovf1), .all_done(ad1));

  int n_pass = 0, n_total = 0, n_fail = 0;

  // Model phases: 0 idle, 1 load, 2 drain, 3 solve, 4 done.
  int          m_ph   [2];
  int          m_cnt  [2];
  int          m_addr [2];
  bit          m_ovf  [2];
  bit          m_start[2];
  logic [29:0] m_q    [2][$];

  function automatic int cap_of(input int k);
    return (k == 0) ? 4096 : 4;
  endfunction

  function automatic logic exp_ovf(input int k);
`ifdef GRAPH_LOAD_OVERFLOW_FLAG_EN
    return m_ovf[k];
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = 0; m_cnt[k] = 0; m_addr[k] = 0; m_ovf[k] = 1'b0; m_start[k] = 1'b0;
      m_q[k].delete();
    end
  endtask

  task automatic check_outs();
    for (int k = 0; k < 2; k++) begin
      logic en_e;
      string p;
      p = (k == 0) ? "big" : "small";
      en_e = ((m_ph[k] == 1) || (m_ph[k] == 2)) && (m_q[k].size() > 0);
      chk({p, ".wr_en"}, k ? en1 : en0, en_e);
      if (en_e) chk({p, ".wr_data"}, k ? data1 : data0, m_q[k][0]);
      chk({p, ".wr_addr"},      k ? addr1 : addr0, m_addr[k]);
      chk({p, ".edge_count"},   k ? cnt1 : cnt0, m_cnt[k]);
      chk({p, ".overflow"},     k ? ovf1 : ovf0, exp_ovf(k));
      chk({p, ".solver_start"}, k ? st1 : st0, m_start[k]);
      chk({p, ".all_done"},     k ? ad1 : ad0, m_ph[k] == 4);
    end
  endtask

  // One clock: drive at negedge, check current outputs, advance model, settle to next negedge.
  task automatic step(input bit ev, input bit dn, input bit rdy, input bit sd);
    logic [29:0] e;
    src_node = NW'($urandom); dst_node = NW'($urandom);
    e = {src_node, dst_node};
    edge_valid = ev; decoding_done = dn; ram_wr_ready = rdy; solver_done = sd;
    check_outs();
    for (int k = 0; k < 2; k++) begin
      int  sz, nph;
      bit  en_e, pop, drop;
      sz   = m_q[k].size();
      nph  = m_ph[k];
      en_e = ((m_ph[k] == 1) || (m_ph[k] == 2)) && (sz > 0);
      pop  = en_e && rdy;
      drop = ((sz == DEPTH) && !pop) || (m_cnt[k] + sz >= cap_of(k));
      if (pop) begin
        void'(m_q[k].pop_front());
        m_cnt[k]++;
        m_addr[k] = (m_addr[k] + 1) % cap_of(k);
      end
      if (m_ph[k] <= 1 && ev) begin
        if (drop) m_ovf[k] = 1'b1;
        else      m_q[k].push_back(e);
      end
      case (m_ph[k])
        0: if (dn) nph = 2; else if (ev) nph = 1;
        1: if (dn) nph = 2;
        2: if (sz == 0) nph = 3;
        3: if (sd) nph = 4;
        default: nph = m_ph[k];
      endcase
      m_start[k] = (nph == 3) && (m_ph[k] != 3);
      m_ph[k]    = nph;
    end
    @(posedge clk);
    @(negedge clk);
    edge_valid = 1'b0; decoding_done = 1'b0; solver_done = 1'b0;
  endtask

  // Async reset mid-cycle, then release with an edge that must be ignored.
  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    chk("rst.big.wr_en", en0, 1'b0);        chk("rst.small.wr_en", en1, 1'b0);
    chk("rst.big.wr_addr", addr0, 12'd0);   chk("rst.small.wr_addr", addr1, 2'd0);
    chk("rst.big.wr_data", data0, 30'd0);   chk("rst.small.wr_data", data1, 30'd0);
    chk("rst.big.edge_count", cnt0, 13'd0); chk("rst.small.edge_count", cnt1, 3'd0);
    chk("rst.big.solver_start", st0, 1'b0); chk("rst.big.overflow", ovf0, 1'b0);
    chk("rst.small.overflow", ovf1, 1'b0);  chk("rst.big.all_done", ad0, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    edge_valid = 1'b1; src_node = NW'($urandom); dst_node = NW'($urandom);
    @(posedge clk);
    @(negedge clk);
    edge_valid = 1'b0;
    chk("release.big.wr_en", en0, 1'b0);
    chk("release.small.wr_en", en1, 1'b0);
    chk("release.big.edge_count", cnt0, 13'd0);
  endtask

  // End input, drain with ready held high, launch and finish the solver, then poke ignored inputs.
  task automatic finish_run();
    step(0, 1, 1, 0);
    for (int i = 0; i < 40; i++) begin
      if (m_ph[0] >= 3 && m_ph[1] >= 3) break;
      step(0, 0, 1, 0);
    end
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    step(1, 1, 1, 0);
    step(1, 0, 0, 1);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    reset_pulse();

    // Five edges with RAM always ready; stray solver_done during load.
    for (int i = 0; i < 5; i++) step(1, 0, 1, i == 2);
    finish_run();
    chk("basic.big.edge_count", cnt0, 13'd5);

    // RAM stalled while ten edges arrive back to back.
    reset_pulse();
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++)  step(0, 0, 0, 0);
    finish_run();
    chk("stall.big.edge_count", cnt0, 13'd8);
    chk("stall.small.edge_count", cnt1, 3'd4);

    // Ready toggling every cycle with random edge arrivals.
    reset_pulse();
    for (int i = 0; i < 20; i++) step(($urandom % 3) != 0, 0, i[0], 0);
    finish_run();

    // Empty graph.
    reset_pulse();
    finish_run();
    chk("empty.big.edge_count", cnt0, 13'd0);

    // Six edges into a four-entry RAM.
    reset_pulse();
    for (int i = 0; i < 6; i++) step(1, 0, 1, 0);
    finish_run();
    chk("cap.small.edge_count", cnt1, 3'd4);
    chk("cap.small.wr_addr", addr1, 2'd0);

    // Reset while draining three buffered edges, then a fresh run.
    reset_pulse();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    reset_pulse();
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0);
    finish_run();
    chk("rerun.big.edge_count", cnt0, 13'd3);

    // Random runs.
    for (int r = 0; r < 4; r++) begin
      int n;
      reset_pulse();
      n = $urandom_range(5, 30);
      for (int i = 0; i < n; i++)
        step(($urandom % 4) != 0, 0, ($urandom % 3) != 0, ($urandom % 8) == 0);
      finish_run();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
